// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencer for a square matrix multiply C = A x B.
// Walks result elements in row-major order. For each element it spends `row`
// FETCH cycles reading A[i][k] and B[k][j] from asynchronous-read memories and
// accumulating their product, then spends one WRITE cycle storing the sum in C.
// A one-cycle done pulse follows the last write.
// Optional feature: define MATMUL_SATURATE_EN to clamp the accumulator at
// 2^out_size-1 instead of letting it wrap modulo 2^out_size.
module matmul_ctrl #(
  parameter int row      = 2,
  parameter int column   = 2,
  parameter int size     = 8,
  parameter int out_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                a_read,
  output logic                b_read,
  output logic [5:0]          a_read_address,
  output logic [5:0]          b_read_address,
  input  logic [size-1:0]     a_data,
  input  logic [size-1:0]     b_data,
  output logic                c_write,
  output logic [5:0]          c_write_address,
  output logic [out_size-1:0] c_write_value,
  output logic                busy,
  output logic                done
);

  localparam int         PROD_W = 2 * size;
  localparam int         SUM_W  = out_size + PROD_W + 1;
  localparam logic [5:0] ROW_W  = 6'(row);
  localparam logic [5:0] LAST_K = 6'(row - 1);
  localparam logic [5:0] LAST_I = 6'(row - 1);
  localparam logic [5:0] LAST_J = 6'(column - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [5:0]          i;
  logic [5:0]          j;
  logic [5:0]          k;
  logic [out_size-1:0] acc;
  logic [PROD_W-1:0]   prod;

  // Accumulate one product; the sum is formed wide enough that no carry is
  // lost, so overflow shows up as any bit set above the result width.
  function automatic logic [out_size-1:0] acc_add(input logic [out_size-1:0] a,
                                                  input logic [PROD_W-1:0]   p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(p);
`ifdef MATMUL_SATURATE_EN
    if (s[SUM_W-1:out_size] != '0) return '1;
`endif
    return s[out_size-1:0];
  endfunction

  assign prod = PROD_W'(a_data) * PROD_W'(b_data);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and Moore outputs; every output defaults to 0 outside its state.
  always_comb begin
    state_nxt       = state;
    a_read          = 1'b0;
    b_read          = 1'b0;
    a_read_address  = '0;
    b_read_address  = '0;
    c_write         = 1'b0;
    c_write_address = '0;
    c_write_value   = '0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy           = 1'b1;
        a_read         = 1'b1;
        b_read         = 1'b1;
        a_read_address = ROW_W * i + k;
        b_read_address = ROW_W * k + j;
        if (k == LAST_K) state_nxt = WRITE;
      end
      WRITE: begin
        busy            = 1'b1;
        c_write         = 1'b1;
        c_write_address = ROW_W * i + j;
        c_write_value   = acc;
        state_nxt       = (i == LAST_I && j == LAST_J) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Element indices and accumulator; cleared at start and after every write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
          end
        end
        FETCH: begin
          acc <= acc_add(acc, prod);
          k   <= k + 6'd1;
        end
        WRITE: begin
          acc <= '0;
          k   <= '0;
          if (j == LAST_J) begin
            j <= '0;
            i <= i + 6'd1;
          end else begin
            j <= j + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Testbench for matmul_ctrl (2x2, 8-bit operands, 16-bit results).
// The reference model tracks only "cycles since the start edge" and derives
// every expected output from that count and the matrix contents.
module tb_matmul_ctrl;

  localparam int R     = 2;
  localparam int COLS  = 2;
  localparam int SZ    = 8;
  localparam int OSZ   = 16;
  localparam int TOTAL = R * COLS * (R + 1);

  logic           clk;
  logic           rst;
  logic           start;
  logic           a_read, b_read, c_write, busy, done;
  logic [5:0]     a_read_address, b_read_address, c_write_address;
  logic [SZ-1:0]  a_data, b_data;
  logic [OSZ-1:0] c_write_value;

  logic [SZ-1:0]  mem_a [64];
  logic [SZ-1:0]  mem_b [64];
  logic [OSZ-1:0] got_c [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n = 0;
  int t0 = 0;
  bit chk_en = 0;
  int write_cnt, done_cnt, busy_cnt, done_at;

  matmul_ctrl #(.row(R), .column(COLS), .size(SZ), .out_size(OSZ)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_read(a_read), .b_read(b_read),
    .a_read_address(a_read_address), .b_read_address(b_read_address),
    .a_data(a_data), .b_data(b_data),
    .c_write(c_write), .c_write_address(c_write_address),
    .c_write_value(c_write_value),
    .busy(busy), .done(done)
  );

  assign a_data = mem_a[a_read_address];
  assign b_data = mem_b[b_read_address];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected C[i][j] by straightforward dot product with wrap or clamp.
  function automatic logic [31:0] exp_elem(input int ii, input int jj);
    longint acc;
    acc = 0;
    for (int kk = 0; kk < R; kk++) begin
      acc = acc + longint'(mem_a[R*ii+kk]) * longint'(mem_b[R*kk+jj]);
`ifdef MATMUL_SATURATE_EN
      if (acc > 65535) acc = 65535;
`else
      acc = acc % 65536;
`endif
    end
    return 32'(acc);
  endfunction

  // Model: n = 0 idle, 1..TOTAL busy, TOTAL+1 done-pulse cycle.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      n = 0;
      chk_en = 1;
    end else if (n == 0) begin
      if (start) begin
        n = 1;
        t0 = cyc;
      end
    end else if (n == TOTAL + 1) begin
      n = 0;
    end else begin
      n++;
    end
  end

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0]  ctl_e;
      logic [31:0] aa_e, ba_e, ca_e, cv_e;
      int p, e, ii, jj;
      ctl_e = '0; aa_e = 0; ba_e = 0; ca_e = 0; cv_e = 0;
      if (n >= 1 && n <= TOTAL) begin
        p  = (n - 1) % (R + 1);
        e  = (n - 1) / (R + 1);
        ii = e / COLS;
        jj = e % COLS;
        if (p < R) begin
          ctl_e = 5'b10110;
          aa_e  = R * ii + p;
          ba_e  = R * p + jj;
        end else begin
          ctl_e = 5'b10001;
          ca_e  = R * ii + jj;
          cv_e  = exp_elem(ii, jj);
        end
      end else if (n == TOTAL + 1) begin
        ctl_e = 5'b01000;
      end
      check("ctl{busy,done,a_rd,b_rd,c_wr}", {27'd0, busy, done, a_read, b_read, c_write}, {27'd0, ctl_e});
      check("a_b_addr", {20'd0, a_read_address, b_read_address}, {20'd0, aa_e[5:0], ba_e[5:0]});
      check("c_addr", {26'd0, c_write_address}, ca_e);
      check("c_value", {16'd0, c_write_value}, cv_e);
      if (c_write === 1'b1) begin
        got_c[c_write_address] = c_write_value;
        write_cnt++;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = cyc - t0 + 1;
      end
    end
  end

  task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
    for (int x = 0; x < 64; x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
      got_c[x] = '0;
    end
    mem_a[0] = 8'(a0); mem_a[1] = 8'(a1); mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
    mem_b[0] = 8'(b0); mem_b[1] = 8'(b1); mem_b[2] = 8'(b2); mem_b[3] = 8'(b3);
    write_cnt = 0; done_cnt = 0; busy_cnt = 0; done_at = 0;
  endtask

  // Pulse start for one edge; returns in cycle 1 of the operation.
  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    for (int w = 0; w < 40 && done_cnt == 0; w++) begin
      @(posedge clk); #1;
    end
    check("done_seen", done_cnt, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_c(input int v0, v1, v2, v3);
    check("c[0]", {16'd0, got_c[0]}, v0);
    check("c[1]", {16'd0, got_c[1]}, v1);
    check("c[2]", {16'd0, got_c[2]}, v2);
    check("c[3]", {16'd0, got_c[3]}, v3);
    check("write_count", write_cnt, 4);
  endtask

  initial begin
    rst = 0;
    start = 0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    @(posedge clk); #1;

    // Square of [[5,6],[7,8]]
    load(5, 6, 7, 8, 5, 6, 7, 8);
    pulse_start();
    wait_done();
    check_c(67, 78, 91, 106);
    check("done_cycle", done_at, 13);

    // [[1,2],[3,4]] x [[5,6],[7,8]]
    load(1, 2, 3, 4, 5, 6, 7, 8);
    pulse_start();
    wait_done();
    check_c(19, 22, 43, 50);
    check("busy_cycles", busy_cnt, 12);

    // All-255 operands: overflow boundary
    load(255, 255, 255, 255, 255, 255, 255, 255);
    pulse_start();
    wait_done();
`ifdef MATMUL_SATURATE_EN
    check_c(65535, 65535, 65535, 65535);
`else
    check_c(64514, 64514, 64514, 64514);
`endif

    // start re-asserted on cycles 3 and 7 must be ignored
    load(1, 2, 3, 4, 5, 6, 7, 8);
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();
    check_c(19, 22, 43, 50);
    check("done_pulses", done_cnt, 1);

    // reset at cycle 5 aborts; nothing happens until a new start
    load(5, 6, 7, 8, 5, 6, 7, 8);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    write_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_write", write_cnt, 0);
    load(5, 6, 7, 8, 5, 6, 7, 8);
    pulse_start();
    wait_done();
    check_c(67, 78, 91, 106);
    check("done_cycle_after_abort", done_at, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter row, default 2: rows of A, B and C (square; row = column).
REQ-002 SHALL have parameter column, default 2: columns of A, B and C, equal to row.
REQ-003 SHALL have parameter size, default 8: operand width in bits (unsigned).
REQ-004 SHALL have parameter out_size, default 16: result/accumulator width in bits (unsigned).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request one full multiply C = A x B.
REQ-008 SHALL have ports a_read / b_read  output  1  read enables to operand memories A / B.
REQ-009 SHALL have ports a_read_address / b_read_address  output  6  operand element addresses.
REQ-010 SHALL have ports a_data / b_data  input  size  async-read data returned by memories A / B.
REQ-011 SHALL have port c_write  output  1  write enable to result memory C.
REQ-012 SHALL have port c_write_address  output  6  result element address.
REQ-013 SHALL have port c_write_value  output  out_size  result element value.
REQ-014 SHALL have ports busy / done  output  1  operation in progress / one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WRITE, DONE.
REQ-016 SHALL move IDLE->FETCH on a rising edge with start=1, clearing i, j, k and the accumulator; in all other states start SHALL be ignored.
REQ-017 SHALL, in each FETCH cycle, drive a_read=b_read=1, a_read_address=row*i+k, b_read_address=row*k+j, and on the clock edge add a_data*b_data to the accumulator (same-cycle async data).
REQ-018 SHALL stay in FETCH for exactly row cycles per element (k=0..row-1), then go to WRITE.
REQ-019 SHALL, in WRITE, drive c_write=1 for exactly one cycle with c_write_address=row*i+j and c_write_value=accumulator, then clear the accumulator and k.
REQ-020 SHALL iterate elements in row-major order (j fastest); after the WRITE of element (row-1, column-1) go to DONE, otherwise go to FETCH.
REQ-021 SHALL assert done=1 only in DONE (exactly one cycle), then return to IDLE.
REQ-022 SHALL assert busy=1 in FETCH and WRITE only.
REQ-023 SHALL hold a_read, b_read, c_write at 0 and all address and value outputs at 0 outside FETCH/WRITE respectively.
REQ-024 SHALL take row*column*(row+1) cycles from the start edge to the last WRITE, with done high in the following cycle (13th cycle after the start edge for 2x2).
REQ-025 SHALL perform accumulation modulo 2^out_size (wrap) when the saturation feature is compiled out.
REQ-026 SHALL keep address bits above those required for row*column-1 at 0.

Reset
REQ-027 SHALL, when rst=0 on a rising edge, go to IDLE and clear i, j, k, the accumulator, busy and done; rst=0 SHALL override start.
REQ-028 SHALL, on reset mid-operation, issue no further c_write and resume only on a new start after rst=1.

Configuration
REQ-029 SHALL, with macro MATMUL_SATURATE_EN defined, clamp the accumulator to 2^out_size-1 on any addition that would overflow, staying clamped for the rest of that element.
REQ-030 SHALL, without MATMUL_SATURATE_EN, wrap as in REQ-025; no other behaviour SHALL differ.

Verification
REQ-031 SHALL cover A=[[5,6],[7,8]], B=[[5,6],[7,8]], start pulse -> c_write at addresses 0,1,2,3 with values 67,78,91,106, done high in the 13th cycle after start.
REQ-032 SHALL cover A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes 19,22,43,50 at addresses 0..3, busy high for exactly 12 cycles.
REQ-033 SHALL cover size=8, all A and B elements 255 -> every write value 64514 without MATMUL_SATURATE_EN, 65535 with it.
REQ-034 SHALL cover start re-asserted on cycles 3 and 7 of an operation -> ignored, exactly 4 writes, one done pulse.
REQ-035 SHALL cover rst=0 at cycle 5 of an operation -> next cycle busy=0, done=0, no c_write until a new start; new start -> correct full result.
